// File: rtl/i2c_cmd_sequencer_pkg.sv
// i2c_seq_pkg: command op codes, sequencer states and command width
package i2c_seq_pkg;
  localparam int CMD_W = 10;
  typedef enum logic [1:0] {OP_START = 2'b00, OP_WRITE = 2'b01, OP_READ = 2'b10, OP_STOP = 2'b11} op_t;
  typedef enum logic [2:0] {IDLE, ADDR, NEXT, XFER, FLUSH, STOP_WAIT} state_t;
endpackage

// File: rtl/i2c_cmd_sequencer_if.sv
// i2c_cmd_sequencer_if: command push, controller status/drive and APB-side results
interface i2c_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [9:0] cmd_data;
  logic       byte_done;
  logic       ack_ok;
  logic [7:0] ctrl_rd_data;
  logic       bus_idle;
  logic       enable;
  logic [7:0] slave_address;
  logic [7:0] data_in;
  logic       repeated_start_cond;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy;
  logic       nack_err;
  logic       seq_err;
  logic       err_clr;
  modport slave (
    input  cmd_valid, cmd_data, byte_done, ack_ok, ctrl_rd_data, bus_idle, err_clr,
    output cmd_ready, enable, slave_address, data_in, repeated_start_cond, rd_valid, rd_data,
           busy, nack_err, seq_err
  );
  modport master (
    output cmd_valid, cmd_data, byte_done, ack_ok, ctrl_rd_data, bus_idle, err_clr,
    input  cmd_ready, enable, slave_address, data_in, repeated_start_cond, rd_valid, rd_data,
           busy, nack_err, seq_err
  );
endinterface

// File: rtl/i2c_cmd_fifo.sv
// i2c_cmd_fifo: synchronous command FIFO with combinational head read
module i2c_cmd_fifo
  import i2c_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             i2c_clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [CMD_W-1:0] wdata,
  output logic [CMD_W-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  assign rdata = mem[rptr];
  assign full  = count[AW];
  assign empty = count == '0;
  // storage array, no reset needed since entries are only read below count
  always_ff @(posedge i2c_clk)
    if (push) mem[wptr] <= wdata;
  // pointers wrap naturally at DEPTH; simultaneous push and pop leave count unchanged
  always_ff @(posedge i2c_clk or negedge rst_n)
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
endmodule

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: paces queued I2C commands into the byte controller one transfer at a time
module i2c_cmd_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input logic                  i2c_clk,
  input logic                  rst_n,
  i2c_cmd_sequencer_if.slave   bus
);
  state_t           state, state_n;
  logic [CMD_W-1:0] head;
  logic [AW:0]      count;
  logic             full, empty, push, pop;
  logic             enable_n, rsc_n, rd_valid_n, nack_set, seq_set;
  logic [7:0]       addr_n, data_n;
  op_t              head_op;
  logic [7:0]       head_byte;
  assign head_op       = op_t'(head[CMD_W-1:8]);
  assign head_byte     = head[7:0];
  assign bus.cmd_ready = !full;
  // while full, a push is still taken in a cycle that pops, refilling the freed slot
  assign push          = bus.cmd_valid && (!full || pop);
  assign bus.busy      = state != IDLE || count != '0;
  i2c_cmd_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .i2c_clk (i2c_clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wdata   (bus.cmd_data),
    .rdata   (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );
  // next-state, pop decision and next values of the controller-facing registers
  always_comb begin
    state_n    = state;
    pop        = 1'b0;
    enable_n   = bus.enable;
    addr_n     = bus.slave_address;
    data_n     = bus.data_in;
    rsc_n      = bus.repeated_start_cond;
    rd_valid_n = 1'b0;
    nack_set   = 1'b0;
    seq_set    = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop = 1'b1;
        if (head_op == OP_START) begin
          addr_n   = head_byte;
          enable_n = 1'b1;
          rsc_n    = 1'b0;
          state_n  = ADDR;
        end else seq_set = 1'b1;
      end
      ADDR: if (bus.byte_done) begin
        if (!bus.ack_ok) begin
          nack_set = 1'b1;
          enable_n = 1'b0;
          state_n  = FLUSH;
        end else begin
          rsc_n   = 1'b0;
          state_n = NEXT;
        end
      end
      NEXT: if (empty || head_op == OP_STOP) begin
        pop      = !empty;
        enable_n = 1'b0;
        state_n  = STOP_WAIT;
      end else if (head_op == OP_START) begin
        pop     = 1'b1;
        addr_n  = head_byte;
        rsc_n   = 1'b1;
        state_n = ADDR;
      end else if ((head_op == OP_WRITE) != bus.slave_address[0]) begin
        pop     = 1'b1;
        data_n  = head_op == OP_WRITE ? head_byte : bus.data_in;
        state_n = XFER;
      end else begin
        seq_set  = 1'b1;
        enable_n = 1'b0;
        state_n  = FLUSH;
      end
      XFER: if (bus.byte_done) begin
        rd_valid_n = bus.slave_address[0];
        state_n    = NEXT;
        if (!bus.slave_address[0] && !bus.ack_ok) begin
          nack_set = 1'b1;
          enable_n = 1'b0;
          state_n  = FLUSH;
        end
      end
      FLUSH: begin
        enable_n = 1'b0;
        pop      = !empty;
        state_n  = empty || head_op == OP_STOP ? STOP_WAIT : FLUSH;
      end
      STOP_WAIT: state_n = bus.bus_idle ? IDLE : STOP_WAIT;
      default: state_n = IDLE;
    endcase
  end
  // state, output registers and sticky errors; error set wins over clear
  always_ff @(posedge i2c_clk or negedge rst_n)
    if (!rst_n) begin
      state                   <= IDLE;
      bus.enable              <= 1'b0;
      bus.slave_address       <= '0;
      bus.data_in             <= '0;
      bus.repeated_start_cond <= 1'b0;
      bus.rd_valid            <= 1'b0;
      bus.rd_data             <= '0;
      bus.nack_err            <= 1'b0;
      bus.seq_err             <= 1'b0;
    end else begin
      state                   <= state_n;
      bus.enable              <= enable_n;
      bus.slave_address       <= addr_n;
      bus.data_in             <= data_n;
      bus.repeated_start_cond <= rsc_n;
      bus.rd_valid            <= rd_valid_n;
      if (rd_valid_n) bus.rd_data <= bus.ctrl_rd_data;
      bus.nack_err            <= nack_set || (bus.nack_err && !bus.err_clr);
      bus.seq_err             <= seq_set || (bus.seq_err && !bus.err_clr);
    end
endmodule
